// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//   Memory-access stage of the 16-bit pipeline. It takes instructions from the
//   EX/MEM register and hands results to the MEM/WB register.
//
//   - Non-memory instructions complete in one cycle and the stage stays IDLE.
//   - A load or store starts a req/ready transaction with data memory. While
//     the transaction is outstanding the FSM is in BUSY and stall is high.
//   - A store always wins over a load when both mem_read and mem_write are set.
//
//   Optional feature, macro MEM_TIMEOUT_EN:
//     When it is defined, an 8-bit wait counter limits the time spent in BUSY
//     to TIMEOUT cycles. If no ready arrives in that time, the op is retired
//     with wb_data=0 and wb_reg_write=0, and mem_fault pulses for one cycle.
//     When it is undefined, there is no counter and no mem_fault port, and
//     BUSY waits for dmem_ready indefinitely.
// -----------------------------------------------------------------------------
module mem_stage #(
    parameter int DATA_W  = 16,
    parameter int RD_W    = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              ex_valid,
    input  logic              ex_reg_write,
    input  logic              ex_reg_store,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [DATA_W-1:0] ex_3rd_arg,
    input  logic [RD_W-1:0]   ex_rd,

    output logic              stall,

    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ready,
    input  logic [DATA_W-1:0] dmem_rdata,

    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic              wb_reg_store,
    output logic [DATA_W-1:0] wb_data,
    output logic [RD_W-1:0]   wb_rd
`ifdef MEM_TIMEOUT_EN
    ,
    output logic              mem_fault
`endif
);

    // The wait counter is 8 bits wide, so TIMEOUT must fit in 1..255.
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("mem_stage: TIMEOUT must be in 1..255");
    end

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    // Control fields of the memory op in flight. The address and the store
    // flag are already held on dmem_addr and dmem_we, so they are not copied.
    logic            cap_reg_write;
    logic            cap_reg_store;
    logic [RD_W-1:0] cap_rd;

    logic accept;
    logic is_mem_op;
    logic done_ok;
    logic done_fault;

`ifdef MEM_TIMEOUT_EN
    logic [7:0] wait_cnt;
`endif

    assign accept    = (state == IDLE) && ex_valid;
    assign is_mem_op = ex_mem_read | ex_mem_write;
    assign done_ok   = (state == BUSY) && dmem_ready;
    assign stall     = (state == BUSY);

`ifdef MEM_TIMEOUT_EN
    // The fault fires at the end of BUSY cycle number TIMEOUT, when the
    // counter would reach TIMEOUT. A ready in that same cycle still wins.
    assign done_fault = (state == BUSY) && !dmem_ready
                        && (wait_cnt == 8'(TIMEOUT - 1));
`else
    assign done_fault = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with <= so every flop samples the
        // pre-edge values no matter what order the always blocks run in.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: enter BUSY on a memory op, leave on ready or fault.
    always_comb begin
        // NOTE: assign a default first so every path drives state_nxt and no
        // latch is inferred.
        state_nxt = state;
        case (state)
            IDLE:    if (accept && is_mem_op)   state_nxt = BUSY;
            BUSY:    if (done_ok || done_fault) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Memory interface, captured controls and write-back outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            // Outstanding transaction abandoned: request dropped, nothing retired.
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_addr     <= '0;
            dmem_wdata    <= '0;
            cap_reg_write <= 1'b0;
            cap_reg_store <= 1'b0;
            cap_rd        <= '0;
            wb_valid      <= 1'b0;
            wb_reg_write  <= 1'b0;
            wb_reg_store  <= 1'b0;
            wb_data       <= '0;
            wb_rd         <= '0;
`ifdef MEM_TIMEOUT_EN
            wait_cnt      <= '0;
            mem_fault     <= 1'b0;
`endif
        end else begin
            // wb_valid and mem_fault are pulses. The other wb_* fields hold.
            wb_valid <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            mem_fault <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_mem_op) begin
                            dmem_req      <= 1'b1;
                            dmem_we       <= ex_mem_write;
                            dmem_addr     <= ex_alu_result;
                            dmem_wdata    <= ex_3rd_arg;
                            cap_reg_write <= ex_reg_write;
                            cap_reg_store <= ex_reg_store;
                            cap_rd        <= ex_rd;
`ifdef MEM_TIMEOUT_EN
                            wait_cnt      <= '0;
`endif
                        end else begin
                            wb_valid     <= 1'b1;
                            wb_data      <= ex_alu_result;
                            wb_reg_write <= ex_reg_write;
                            wb_reg_store <= ex_reg_store;
                            wb_rd        <= ex_rd;
                        end
                    end
                end
                BUSY: begin
                    if (done_ok) begin
                        dmem_req     <= 1'b0;
                        wb_valid     <= 1'b1;
                        wb_reg_store <= cap_reg_store;
                        wb_rd        <= cap_rd;
                        if (dmem_we) begin
                            // Stores retire the address and never write a register.
                            wb_data      <= dmem_addr;
                            wb_reg_write <= 1'b0;
                        end else begin
                            wb_data      <= dmem_rdata;
                            wb_reg_write <= cap_reg_write;
                        end
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (done_fault) begin
                        dmem_req     <= 1'b0;
                        wb_valid     <= 1'b1;
                        wb_data      <= '0;
                        wb_reg_write <= 1'b0;
                        wb_reg_store <= cap_reg_store;
                        wb_rd        <= cap_rd;
                        mem_fault    <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
//   Self-checking bench for mem_stage. A transaction-level model tracks what
//   the MEM/WB outputs must show after each instruction. Inputs are driven on
//   the falling edge and outputs are sampled on the next falling edge.
//   Build with +define+MEM_TIMEOUT_EN to also cover the timeout path
//   (TIMEOUT=4).
// -----------------------------------------------------------------------------
module tb_mem_stage;

    localparam int DATA_W = 16;
    localparam int RD_W   = 16;
`ifdef MEM_TIMEOUT_EN
    localparam int TMO      = 4;
    localparam int MAX_WAIT = TMO - 1;
`else
    localparam int MAX_WAIT = 5;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              ex_valid, ex_reg_write, ex_reg_store, ex_mem_read, ex_mem_write;
    logic [DATA_W-1:0] ex_alu_result, ex_3rd_arg;
    logic [RD_W-1:0]   ex_rd;
    logic              stall;
    logic              dmem_req, dmem_we;
    logic [DATA_W-1:0] dmem_addr, dmem_wdata;
    logic              dmem_ready;
    logic [DATA_W-1:0] dmem_rdata;
    logic              wb_valid, wb_reg_write, wb_reg_store;
    logic [DATA_W-1:0] wb_data;
    logic [RD_W-1:0]   wb_rd;
`ifdef MEM_TIMEOUT_EN
    logic              mem_fault;
`endif

    always #5 clk = ~clk;

    mem_stage #(
        .DATA_W(DATA_W),
        .RD_W  (RD_W)
`ifdef MEM_TIMEOUT_EN
        , .TIMEOUT(TMO)
`endif
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ex_valid     (ex_valid),
        .ex_reg_write (ex_reg_write),
        .ex_reg_store (ex_reg_store),
        .ex_mem_read  (ex_mem_read),
        .ex_mem_write (ex_mem_write),
        .ex_alu_result(ex_alu_result),
        .ex_3rd_arg   (ex_3rd_arg),
        .ex_rd        (ex_rd),
        .stall        (stall),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_ready   (dmem_ready),
        .dmem_rdata   (dmem_rdata),
        .wb_valid     (wb_valid),
        .wb_reg_write (wb_reg_write),
        .wb_reg_store (wb_reg_store),
        .wb_data      (wb_data),
        .wb_rd        (wb_rd)
`ifdef MEM_TIMEOUT_EN
        , .mem_fault  (mem_fault)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Model of the MEM/WB fields. They hold between retirements.
    logic [DATA_W-1:0] exp_data;
    logic [RD_W-1:0]   exp_rd;
    logic              exp_rw;
    logic              exp_rs;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_fault(input string tag, input logic exp);
`ifdef MEM_TIMEOUT_EN
        check(tag, mem_fault, exp);
`endif
    endtask

    task automatic check_wb_fields(input string tag);
        check({tag, ".wb_data"},      wb_data,      exp_data);
        check({tag, ".wb_rd"},        wb_rd,        exp_rd);
        check({tag, ".wb_reg_write"}, wb_reg_write, exp_rw);
        check({tag, ".wb_reg_store"}, wb_reg_store, exp_rs);
    endtask

    // Drive arbitrary values. Used where the DUT must ignore the inputs.
    task automatic drive_noise();
        ex_reg_write  = 1'($urandom);
        ex_reg_store  = 1'($urandom);
        ex_mem_read   = 1'($urandom);
        ex_mem_write  = 1'($urandom);
        ex_alu_result = 16'($urandom);
        ex_3rd_arg    = 16'($urandom);
        ex_rd         = 16'($urandom);
        dmem_rdata    = 16'($urandom);
    endtask

    task automatic expect_reset_state(input string tag);
        check({tag, ".stall"},    stall,    1'b0);
        check({tag, ".dmem_req"}, dmem_req, 1'b0);
        check({tag, ".dmem_we"},  dmem_we,  1'b0);
        check({tag, ".wb_valid"}, wb_valid, 1'b0);
        check_fault({tag, ".mem_fault"}, 1'b0);
        check_wb_fields(tag);
    endtask

    // One cycle with no instruction: no pulse, and the wb fields hold.
    task automatic idle_cycle();
        drive_noise();
        ex_valid   = 1'b0;
        dmem_ready = 1'($urandom);
        @(negedge clk);
        check("idle.wb_valid", wb_valid, 1'b0);
        check("idle.stall",    stall,    1'b0);
        check("idle.dmem_req", dmem_req, 1'b0);
        check_wb_fields("idle");
    endtask

    // Non-memory op: retires on the next edge.
    task automatic do_alu(input logic [15:0] alu, input logic [15:0] rd,
                          input logic rw, input logic rs);
        drive_noise();
        ex_valid      = 1'b1;
        ex_mem_read   = 1'b0;
        ex_mem_write  = 1'b0;
        ex_alu_result = alu;
        ex_rd         = rd;
        ex_reg_write  = rw;
        ex_reg_store  = rs;
        dmem_ready    = 1'($urandom);
        @(negedge clk);
        exp_data = alu;
        exp_rd   = rd;
        exp_rw   = rw;
        exp_rs   = rs;
        check("alu.wb_valid", wb_valid, 1'b1);
        check("alu.stall",    stall,    1'b0);
        check("alu.dmem_req", dmem_req, 1'b0);
        check_wb_fields("alu");
    endtask

    // Memory op: n_wait BUSY cycles without ready, then one cycle with ready.
    task automatic do_mem(input logic rd_f, input logic wr_f,
                          input logic [15:0] addr, input logic [15:0] arg,
                          input logic [15:0] rd, input logic rw, input logic rs,
                          input int n_wait, input logic [15:0] rdata);
        drive_noise();
        ex_valid      = 1'b1;
        ex_mem_read   = rd_f;
        ex_mem_write  = wr_f;
        ex_alu_result = addr;
        ex_3rd_arg    = arg;
        ex_rd         = rd;
        ex_reg_write  = rw;
        ex_reg_store  = rs;
        dmem_ready    = 1'($urandom);
        @(negedge clk);
        for (int i = 0; i <= n_wait; i++) begin
            check("busy.stall",      stall,      1'b1);
            check("busy.dmem_req",   dmem_req,   1'b1);
            check("busy.dmem_we",    dmem_we,    wr_f);
            check("busy.dmem_addr",  dmem_addr,  addr);
            check("busy.dmem_wdata", dmem_wdata, arg);
            check("busy.wb_valid",   wb_valid,   1'b0);
            drive_noise();
            ex_valid   = 1'($urandom);
            dmem_ready = (i == n_wait);
            if (i == n_wait) dmem_rdata = rdata;
            @(negedge clk);
        end
        exp_data = wr_f ? addr : rdata;
        exp_rw   = wr_f ? 1'b0 : rw;
        exp_rd   = rd;
        exp_rs   = rs;
        check("mem.wb_valid", wb_valid, 1'b1);
        check("mem.stall",    stall,    1'b0);
        check("mem.dmem_req", dmem_req, 1'b0);
        check_fault("mem.mem_fault", 1'b0);
        check_wb_fields("mem");
        dmem_ready = 1'b0;
    endtask

    // Reset in the first BUSY cycle, then a late ready that must be ignored.
    task automatic reset_in_busy();
        drive_noise();
        ex_valid      = 1'b1;
        ex_mem_read   = 1'b1;
        ex_mem_write  = 1'b0;
        ex_alu_result = 16'h0123;
        dmem_ready    = 1'b0;
        @(negedge clk);
        check("rbusy.stall", stall, 1'b1);
        ex_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        reset      = 1'b0;
        exp_data   = '0;
        exp_rd     = '0;
        exp_rw     = 1'b0;
        exp_rs     = 1'b0;
        expect_reset_state("rbusy.after_reset");
        dmem_ready = 1'b1;
        dmem_rdata = 16'hDEAD;
        @(negedge clk);
        check("rbusy.late_ready.wb_valid", wb_valid, 1'b0);
        check("rbusy.late_ready.dmem_req", dmem_req, 1'b0);
        check("rbusy.late_ready.stall",    stall,    1'b0);
        check_wb_fields("rbusy.late_ready");
        dmem_ready = 1'b0;
    endtask

`ifdef MEM_TIMEOUT_EN
    // Load with ready held low: faults after TMO BUSY cycles.
    task automatic do_timeout(input logic [15:0] rd, input logic rs);
        drive_noise();
        ex_valid      = 1'b1;
        ex_mem_read   = 1'b1;
        ex_mem_write  = 1'b0;
        ex_alu_result = 16'h0080;
        ex_rd         = rd;
        ex_reg_write  = 1'b1;
        ex_reg_store  = rs;
        dmem_ready    = 1'b0;
        @(negedge clk);
        for (int i = 0; i < TMO; i++) begin
            check("tmo.stall",     stall,     1'b1);
            check("tmo.dmem_req",  dmem_req,  1'b1);
            check("tmo.mem_fault", mem_fault, 1'b0);
            drive_noise();
            ex_valid   = 1'b0;
            dmem_ready = 1'b0;
            @(negedge clk);
        end
        exp_data = '0;
        exp_rw   = 1'b0;
        exp_rd   = rd;
        exp_rs   = rs;
        check("tmo.fault",    mem_fault, 1'b1);
        check("tmo.wb_valid", wb_valid,  1'b1);
        check("tmo.stall",    stall,     1'b0);
        check("tmo.dmem_req", dmem_req,  1'b0);
        check_wb_fields("tmo");
        idle_cycle();
        check("tmo.fault_pulse", mem_fault, 1'b0);
    endtask
`endif

    initial begin
        reset    = 1'b1;
        ex_valid = 1'b0;
        dmem_ready = 1'b0;
        drive_noise();
        exp_data = '0;
        exp_rd   = '0;
        exp_rw   = 1'b0;
        exp_rs   = 1'b0;
        repeat (2) @(negedge clk);
        expect_reset_state("reset");
        reset = 1'b0;

        // Directed cases.
        do_alu(16'h1234, 16'd3, 1'b1, 1'b0);
        idle_cycle();
        do_mem(1'b1, 1'b0, 16'h0040, 16'h5555, 16'd5, 1'b1, 1'b0, 2, 16'hBEEF);
        do_mem(1'b0, 1'b1, 16'h0010, 16'h00AA, 16'd6, 1'b1, 1'b1, 0, 16'h0000);
        do_mem(1'b1, 1'b1, 16'h0020, 16'h0077, 16'd7, 1'b1, 1'b0, 1, 16'hCAFE);
        do_mem(1'b1, 1'b0, 16'h0044, 16'h0000, 16'd8, 1'b0, 1'b1, 0, 16'h1357);
        reset_in_busy();
        do_alu(16'h0F0F, 16'd9, 1'b1, 1'b1);
`ifdef MEM_TIMEOUT_EN
        do_timeout(16'd11, 1'b1);
        do_mem(1'b1, 1'b0, 16'h00C0, 16'h0000, 16'd12, 1'b1, 1'b0, TMO - 1, 16'h2468);
`endif

        // Randomized mix of ALU ops, loads, stores and idle cycles.
        for (int n = 0; n < 60; n++) begin
            int kind;
            kind = int'($urandom_range(0, 3));
            case (kind)
                0: do_alu(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
                1: do_mem(1'b1, 1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                          1'($urandom), 1'($urandom),
                          int'($urandom_range(0, MAX_WAIT)), 16'($urandom));
                2: do_mem(1'($urandom), 1'b1, 16'($urandom), 16'($urandom), 16'($urandom),
                          1'($urandom), 1'($urandom),
                          int'($urandom_range(0, MAX_WAIT)), 16'($urandom));
                default: idle_cycle();
            endcase
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
